// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: word handshake between a host (register or FIFO) and the
// uart_tx_frame transmitter.
//   tx_data  - word to send, DATA_BITS wide
//   tx_valid - tx_data holds a word to send
//   tx_ready - transmitter can accept a word this cycle
// Modports: master = host side, slave = transmitter side.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter. Sends one word per valid/ready
// handshake as start bit, DATA_BITS data bits LSB-first, optional parity bit,
// then STOP_BITS stop bits. Bit period is (baud_div+1) clk cycles, with
// baud_div latched at accept.
// Optional feature: define UART_TX_PARITY_EN to add the parity bit (even when
// PARITY_ODD=0, odd when PARITY_ODD=1). Undefined: no parity state or logic.
// Ports:
//   clk      - system clock
//   reset_n  - synchronous active-low reset
//   baud_div - bit period minus one, in clk cycles (must be >= 1)
//   host     - uart_tx_frame_if slave: tx_data, tx_valid in; tx_ready out
//              (tx_ready is combinational, high only in IDLE)
//   txd      - serial line, idles high (registered)
//   busy     - frame in progress (registered)
//   tx_done  - one-cycle pulse in the final stop-bit cycle (registered)
module uart_tx_frame #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned DIV_WIDTH  = 16
`ifdef UART_TX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  uart_tx_frame_if.slave       host,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] baud_q, baud_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif
  logic                 bit_end;
  logic                 txd_d;
  logic                 busy_d;
  logic                 done_d;

  // Ready straight from the state register so the host sees it the cycle after STOP.
  assign host.tx_ready = (state_q == IDLE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
      txd      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
      txd      <= txd_d;
      busy     <= busy_d;
      tx_done  <= done_d;
    end
  end

  // Next-state, counters and output decode.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    txd_d    = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    bit_end  = (baud_q == div_q);

    // Baud counter runs 0..div_q in every non-idle state.
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + DIV_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (host.tx_valid) begin
          state_d  = START;
          baud_d   = '0;
          bit_d    = '0;
          div_d    = baud_div;
          shift_d  = host.tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = (^host.tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
`endif
      STOP: begin
        // Bit counter reused to count stop bits.
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are decoded from next-state values so the registered copies line up with state_q.
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == div_d) && (bit_d == LAST_STOP);
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: two transmitters (1 and 2 stop bits; even and odd parity
// when UART_TX_PARITY_EN is defined) driven by directed steps. Each word sent
// is pushed to a per-DUT queue; a bench-side frame model pops it on accept and
// checks txd, busy, tx_done and tx_ready every cycle on the falling edge.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] div;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_v [2];
  logic [15:0] div_v [2];
  logic [1:0]  valid_v;
  logic [1:0]  txd_w, busy_w, done_w, ready_w;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_fail   = 0;
  frame_t exp_q [2][$];
  frame_t cur [2];
  logic   active [2];
  int     cyc [2];
  int     acc_cnt [2];
  int     done_cnt [2];
  logic   started = 1'b0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8)) bus_a ();
  uart_tx_frame_if #(.DATA_BITS(8)) bus_b ();

  assign bus_a.tx_data  = data_v[0];
  assign bus_a.tx_valid = valid_v[0];
  assign ready_w[0]     = bus_a.tx_ready;
  assign bus_b.tx_data  = data_v[1];
  assign bus_b.tx_valid = valid_v[1];
  assign ready_w[1]     = bus_b.tx_ready;

  uart_tx_frame #(
    .DATA_BITS(8), .STOP_BITS(1), .DIV_WIDTH(16)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(0)
`endif
  ) dut_a (
    .clk(clk), .reset_n(rst_n), .baud_div(div_v[0]), .host(bus_a),
    .txd(txd_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
  );

  uart_tx_frame #(
    .DATA_BITS(8), .STOP_BITS(2), .DIV_WIDTH(16)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(1)
`endif
  ) dut_b (
    .clk(clk), .reset_n(rst_n), .baud_div(div_v[1]), .host(bus_b),
    .txd(txd_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
  );

  function automatic int stop_bits(input int g);
    return (g == 0) ? 1 : 2;
  endfunction

  function automatic int frame_len(input int g, input frame_t f);
    return (1 + 8 + PAR + stop_bits(g)) * (int'(f.div) + 1);
  endfunction

  // Expected line level in cycle k (1-based) after accept.
  function automatic logic exp_txd(input int g, input frame_t f, input int k);
    int         idx;
    logic [7:0] d;
    idx = (k - 1) / (int'(f.div) + 1);
    d   = f.data;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR != 0 && idx == 9) return (^d) ^ (g == 1);
    return 1'b1;
  endfunction

  task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, g, $time, obs, exp);
    end
  endtask

  // Model update at the rising edge, using only bench-driven inputs.
  task automatic model_edge();
    for (int g = 0; g < 2; g++) begin
      logic was_idle;
      was_idle = !active[g];
      if (!rst_n) begin
        active[g] = 1'b0;
        cyc[g]    = 0;
        started   = 1'b1;
      end else begin
        if (active[g]) begin
          cyc[g]++;
          if (cyc[g] > frame_len(g, cur[g])) active[g] = 1'b0;
        end
        if (was_idle && valid_v[g] && exp_q[g].size() != 0) begin
          cur[g]    = exp_q[g].pop_front();
          active[g] = 1'b1;
          cyc[g]    = 1;
          acc_cnt[g]++;
        end
      end
    end
  endtask

  // Compare DUT outputs with the model away from the active edge.
  task automatic model_check();
    if (started) begin
      for (int g = 0; g < 2; g++) begin
        if (active[g]) begin
          check("txd",      g, 32'(txd_w[g]),   32'(exp_txd(g, cur[g], cyc[g])));
          check("busy",     g, 32'(busy_w[g]),  32'(1));
          check("tx_done",  g, 32'(done_w[g]),  32'(cyc[g] == frame_len(g, cur[g])));
          check("tx_ready", g, 32'(ready_w[g]), 32'(0));
        end else begin
          check("txd_idle",      g, 32'(txd_w[g]),   32'(1));
          check("busy_idle",     g, 32'(busy_w[g]),  32'(0));
          check("tx_done_idle",  g, 32'(done_w[g]),  32'(0));
          check("tx_ready_idle", g, 32'(ready_w[g]), 32'(1));
        end
        if (done_w[g] === 1'b1) done_cnt[g]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  // Queue the expected frame, present the word and wait for the model to accept it.
  task automatic send(input logic [1:0] mask, input logic [7:0] d, input logic [15:0] div);
    int     target [2];
    int     guard;
    frame_t f;
    f.data = d;
    f.div  = div;
    for (int g = 0; g < 2; g++) begin
      target[g] = acc_cnt[g] + (mask[g] ? 1 : 0);
      if (mask[g]) begin
        exp_q[g].push_back(f);
        data_v[g]  = d;
        div_v[g]   = div;
        valid_v[g] = 1'b1;
      end
    end
    guard = 0;
    while ((acc_cnt[0] < target[0] || acc_cnt[1] < target[1]) && guard < 1000) begin
      tick();
      guard++;
    end
  endtask

  task automatic drop(input logic [1:0] mask);
    valid_v = valid_v & ~mask;
  endtask

  task automatic wait_idle(input logic [1:0] mask);
    int guard;
    guard = 0;
    while (((active[0] && mask[0]) || (active[1] && mask[1])) && guard < 2000) begin
      tick();
      guard++;
    end
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_v = '0;
    for (int g = 0; g < 2; g++) begin
      data_v[g]   = '0;
      div_v[g]    = 16'd3;
      active[g]   = 1'b0;
      cyc[g]      = 0;
      acc_cnt[g]  = 0;
      done_cnt[g] = 0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic frame, 4-cycle bit period.
    send(2'b11, 8'hA5, 16'd3);
    drop(2'b11);
    wait_idle(2'b11);

    // Three ones: even parity bit 1, odd parity bit 0.
    send(2'b11, 8'h07, 16'd1);
    drop(2'b11);
    wait_idle(2'b11);

    // All-zero data, 3-cycle bit period; exercises the 2-stop-bit instance.
    send(2'b11, 8'h00, 16'd2);
    drop(2'b11);
    wait_idle(2'b11);

    // Back-to-back with valid held; data changes right after the first accept.
    send(2'b11, 8'h55, 16'd1);
    send(2'b11, 8'hAA, 16'd1);
    drop(2'b11);
    wait_idle(2'b11);

    // Reset during data bit 3, then a clean frame.
    send(2'b11, 8'hC3, 16'd3);
    drop(2'b11);
    repeat (16) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send(2'b11, 8'h3C, 16'd3);
    drop(2'b11);
    wait_idle(2'b11);

    // Divisor and a stray valid mid-frame must not affect the running frame.
    send(2'b11, 8'h96, 16'd3);
    drop(2'b11);
    repeat (10) tick();
    div_v[0] = 16'd7;
    div_v[1] = 16'd7;
    data_v[0] = 8'hFF;
    data_v[1] = 8'hFF;
    valid_v = 2'b11;
    repeat (3) tick();
    valid_v = 2'b00;
    wait_idle(2'b11);
    send(2'b11, 8'h69, 16'd7);
    drop(2'b11);
    wait_idle(2'b11);

    // Eight frames completed per DUT (the reset one produces no tx_done).
    for (int g = 0; g < 2; g++) begin
      check("done_count", g, 32'(done_cnt[g]), 32'(8));
    end
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
